// File: rtl/sram_stage_scheduler.sv
// Decode pipeline sequencer: runs Milestone 1 then Milestone 2 on a go request,
// muxes the single SRAM port to the active stage and watches each stage for a hang.
//
// state       | meaning
// S_IDLE      | waiting for go
// S_M1_START  | one-cycle start pulse to M1, SRAM granted to M1
// S_M1_WAIT   | waiting for M1_done rising edge, timer running
// S_M2_START  | one-cycle start pulse to M2, SRAM granted to M2
// S_M2_WAIT   | waiting for M2_done rising edge, timer running
// S_DONE      | one-cycle done pulse, SRAM released
// S_ERROR     | a stage hung; error held until go or reset
module sram_stage_scheduler #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 4194304
) (
    input  logic              CLOCK_50_I,
    input  logic              Resetn,
    input  logic              go,
    output logic              M1_start,
    input  logic              M1_done,
    input  logic [ADDR_W-1:0] M1_addr,
    input  logic [DATA_W-1:0] M1_wdata,
    input  logic              M1_we_n,
    output logic              M2_start,
    input  logic              M2_done,
    input  logic [ADDR_W-1:0] M2_addr,
    input  logic [DATA_W-1:0] M2_wdata,
    input  logic              M2_we_n,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic [DATA_W-1:0] SRAM_write_data,
    output logic              SRAM_we_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       run_cycles
);

    localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_M1_START,
        S_M1_WAIT,
        S_M2_START,
        S_M2_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_M1,
        GRANT_M2
    } grant_t;

    state_t               state;
    grant_t               grant;
    logic [TIMER_W-1:0]   timer;
    logic                 M1_done_q;
    logic                 M2_done_q;
    logic                 m1_rise;
    logic                 m2_rise;
    logic                 timer_expired;

    assign m1_rise       = M1_done & ~M1_done_q;
    assign m2_rise       = M2_done & ~M2_done_q;
    assign timer_expired = (timer == TIMER_LAST);

    // Grant decoded straight from state so an async reset releases the SRAM immediately.
    always_comb begin
        case (state)
            S_M1_START, S_M1_WAIT: grant = GRANT_M1;
            S_M2_START, S_M2_WAIT: grant = GRANT_M2;
            default:               grant = GRANT_NONE;
        endcase
    end

    // Zero-latency mux: the stages depend on fixed SRAM read timing.
    always_comb begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        case (grant)
            GRANT_M1: begin
                SRAM_address    = M1_addr;
                SRAM_write_data = M1_wdata;
                SRAM_we_n       = M1_we_n;
            end
            GRANT_M2: begin
                SRAM_address    = M2_addr;
                SRAM_write_data = M2_wdata;
                SRAM_we_n       = M2_we_n;
            end
            default: begin
                SRAM_address    = '0;
                SRAM_write_data = '0;
                SRAM_we_n       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state      <= S_IDLE;
            M1_start   <= 1'b0;
            M2_start   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            run_cycles <= '0;
            timer      <= '0;
            M1_done_q  <= 1'b0;
            M2_done_q  <= 1'b0;
        end else begin
            M1_done_q <= M1_done;
            M2_done_q <= M2_done;
            M1_start  <= 1'b0;
            M2_start  <= 1'b0;
            done      <= 1'b0;

            if (busy && (run_cycles != 32'hFFFF_FFFF)) begin
                run_cycles <= run_cycles + 32'd1;
            end

            case (state)
                S_IDLE, S_ERROR: begin
                    if (go) begin
                        state      <= S_M1_START;
                        M1_start   <= 1'b1;
                        busy       <= 1'b1;
                        error      <= 1'b0;
                        run_cycles <= '0;
                        timer      <= '0;
                    end
                end
                S_M1_START: begin
                    state <= S_M1_WAIT;
                    timer <= '0;
                end
                S_M1_WAIT: begin
                    // A done edge on the final timer cycle still counts as success.
                    if (m1_rise) begin
                        state    <= S_M2_START;
                        M2_start <= 1'b1;
                        timer    <= '0;
                    end else if (timer_expired) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_M2_START: begin
                    state <= S_M2_WAIT;
                    timer <= '0;
                end
                S_M2_WAIT: begin
                    if (m2_rise) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (timer_expired) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_stage_scheduler.sv
// Randomized bench for sram_stage_scheduler: each run is described by a timeline
// (go, stage done edges, timeouts) from which every output is predicted per cycle.
module tb_sram_stage_scheduler;

    localparam int TMO = 128;

    logic        CLOCK_50_I = 1'b0;
    logic        Resetn     = 1'b0;
    logic        go         = 1'b0;
    logic        M1_start;
    logic        M1_done    = 1'b0;
    logic [17:0] M1_addr    = '0;
    logic [15:0] M1_wdata   = '0;
    logic        M1_we_n    = 1'b1;
    logic        M2_start;
    logic        M2_done    = 1'b0;
    logic [17:0] M2_addr    = '0;
    logic [15:0] M2_wdata   = '0;
    logic        M2_we_n    = 1'b1;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] run_cycles;

    int          n_chk    = 0;
    int          n_err    = 0;
    int          cur_t    = 0;
    logic        err_prev = 1'b0;
    logic [31:0] run_prev = '0;

    sram_stage_scheduler #(
        .ADDR_W      (18),
        .DATA_W      (16),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .CLOCK_50_I      (CLOCK_50_I),
        .Resetn          (Resetn),
        .go              (go),
        .M1_start        (M1_start),
        .M1_done         (M1_done),
        .M1_addr         (M1_addr),
        .M1_wdata        (M1_wdata),
        .M1_we_n         (M1_we_n),
        .M2_start        (M2_start),
        .M2_done         (M2_done),
        .M2_addr         (M2_addr),
        .M2_wdata        (M2_wdata),
        .M2_we_n         (M2_we_n),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .run_cycles      (run_cycles)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, cur_t, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_error"}, 64'(error), 64'(0));
        chk({tag, "_m1start"}, 64'(M1_start), 64'(0));
        chk({tag, "_m2start"}, 64'(M2_start), 64'(0));
        chk({tag, "_run"}, 64'(run_cycles), 64'(0));
        chk({tag, "_we_n"}, 64'(SRAM_we_n), 64'(1));
        chk({tag, "_addr"}, 64'(SRAM_address), 64'(0));
        chk({tag, "_wdata"}, 64'(SRAM_write_data), 64'(0));
    endtask

    // Cycle t=0 presents go; M1_start is expected at t=1. d1/d2 are cycles from each
    // start pulse to the stage's done edge; a value above TMO means the stage hangs.
    // h1 keeps M1_done high from the previous run for that many cycles past the start.
    task automatic do_run(input int h1, input int d1, input int d2, input bit noise, input int abort_t);
        int   s1, r1, s2, r2, busy_end, evt_at, last, busy_len, m1_end;
        bit   to1, to2, aborted;
        logic exp_busy, exp_err, exp_we;
        logic [17:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [31:0] exp_run;
        s1       = 1;
        r1       = s1 + d1;
        to1      = (d1 > TMO);
        s2       = r1 + 1;
        r2       = s2 + d2;
        to2      = !to1 && (d2 > TMO);
        busy_end = to1 ? (s1 + TMO) : (to2 ? (s2 + TMO) : r2);
        evt_at   = busy_end + 1;
        last     = busy_end + 2;
        m1_end   = to1 ? busy_end : r1;
        busy_len = busy_end - s1 + 1;
        aborted  = 1'b0;
        for (int t = 0; t <= last; t++) begin
            @(posedge CLOCK_50_I);
            #1;
            cur_t    = t;
            go       = (t == 0) || (noise && t >= s1 && t <= busy_end && $urandom_range(0, 3) == 0);
            M1_done  = (t < s1 + h1) || (!to1 && t >= r1);
            M2_done  = (t < s2) || (!to1 && !to2 && t >= r2);
            M1_addr  = 18'($urandom);
            M1_wdata = 16'($urandom);
            M1_we_n  = 1'($urandom);
            M2_addr  = 18'($urandom);
            M2_wdata = 16'($urandom);
            M2_we_n  = 1'($urandom);
            #1;
            exp_busy = (t >= s1) && (t <= busy_end);
            exp_err  = (t < s1) ? err_prev : ((to1 || to2) && t >= evt_at);
            exp_run  = (t < s1) ? run_prev : 32'((t - s1 < busy_len) ? (t - s1) : busy_len);
            if (t >= s1 && t <= m1_end) begin
                exp_addr = M1_addr; exp_wdata = M1_wdata; exp_we = M1_we_n;
            end else if (!to1 && t >= s2 && t <= busy_end) begin
                exp_addr = M2_addr; exp_wdata = M2_wdata; exp_we = M2_we_n;
            end else begin
                exp_addr = '0; exp_wdata = '0; exp_we = 1'b1;
            end
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("m1_start", 64'(M1_start), 64'(t == s1));
            chk("m2_start", 64'(M2_start), 64'(!to1 && t == s2));
            chk("done", 64'(done), 64'(!to1 && !to2 && t == evt_at));
            chk("error", 64'(error), 64'(exp_err));
            chk("run_cycles", 64'(run_cycles), 64'(exp_run));
            chk("sram_addr", 64'(SRAM_address), 64'(exp_addr));
            chk("sram_wdata", 64'(SRAM_write_data), 64'(exp_wdata));
            chk("sram_we_n", 64'(SRAM_we_n), 64'(exp_we));
            if (t == abort_t) begin
                Resetn = 1'b0;
                go     = 1'b0;
                #1;
                chk_reset_outputs("abort");
                aborted = 1'b1;
                break;
            end
        end
        go = 1'b0;
        if (aborted) begin
            repeat (3) @(posedge CLOCK_50_I);
            #1;
            chk_reset_outputs("held_rst");
            @(negedge CLOCK_50_I);
            Resetn   = 1'b1;
            err_prev = 1'b0;
            run_prev = '0;
        end else begin
            err_prev = to1 || to2;
            run_prev = 32'(busy_len);
        end
    endtask

    initial begin
        int h1, d1, d2;
        #5;
        chk_reset_outputs("reset");
        @(negedge CLOCK_50_I);
        Resetn = 1'b1;
        repeat (2) begin
            @(posedge CLOCK_50_I);
            #2;
            chk_reset_outputs("idle");
        end

        do_run(0, 100, 50, 1'b0, -1);
        do_run(5, 9, 3, 1'b0, -1);
        do_run(0, 20, 30, 1'b1, -1);
        do_run(0, TMO + 40, 5, 1'b0, -1);
        do_run(0, 7, 5, 1'b1, -1);
        do_run(0, TMO, TMO, 1'b0, -1);
        do_run(0, 4, TMO + 1, 1'b1, -1);
        do_run(2, 6, 4, 1'b0, -1);
        do_run(0, 10, 50, 1'b0, 17);
        do_run(0, 12, 8, 1'b0, -1);

        for (int k = 0; k < 12; k++) begin
            h1 = $urandom_range(0, 3);
            d1 = ($urandom_range(0, 7) == 0) ? (TMO - 1 + $urandom_range(0, 2)) : $urandom_range(h1 + 1, 40);
            d2 = ($urandom_range(0, 7) == 0) ? (TMO - 1 + $urandom_range(0, 2)) : $urandom_range(1, 40);
            do_run(h1, d1, d2, 1'($urandom), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
